hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the uDLX 5-stage core. Consumes decoded register addresses from ID, load/writeback info from EX, branch resolution from EX, and a data-memory handshake from MEM. Drives per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Covers load-use stalls, taken-branch/jump squashes and variable-latency memory freezes, with a wait-timeout error and a stall-cycle counter.

---
 rtl/hazard_control_unit_pkg.sv | 42 ++++
 rtl/hazard_control_unit_if.sv | 46 ++++
 rtl/hazard_control_unit_sat_counter.sv | 29 ++
 rtl/hazard_control_unit.sv | 108 ++++++++++
 tb/tb_hazard_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared types and constants for the uDLX pipeline hazard controller.
// Holds the FSM state encoding and the bundle of per-stage control bits.
package hazard_control_unit_pkg;

    localparam int STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } hcu_state_e;

    typedef struct packed {
        logic pc_wr_en;
        logic if_id_wr_en;
        logic id_ex_wr_en;
        logic ex_mem_wr_en;
        logic mem_wb_wr_en;
        logic if_id_flush;
        logic id_ex_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{
        pc_wr_en: 1'b1, if_id_wr_en: 1'b1, id_ex_wr_en: 1'b1,
        ex_mem_wr_en: 1'b1, mem_wb_wr_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0
    };

    localparam stage_ctrl_t CTRL_FREEZE = '{
        pc_wr_en: 1'b0, if_id_wr_en: 1'b0, id_ex_wr_en: 1'b0,
        ex_mem_wr_en: 1'b0, mem_wb_wr_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0
    };

    // Reset holds every stage and keeps NOP bubbles loaded in the front end.
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_wr_en: 1'b0, if_id_wr_en: 1'b0, id_ex_wr_en: 1'b0,
        ex_mem_wr_en: 1'b0, mem_wb_wr_en: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1
    };

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side bundle for the hazard controller: decoded stage info in, stage controls out.
// The slave modport is the controller's view; master is the pipeline's view.
interface hazard_control_unit_if #(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       id_valid_in;
    logic [REG_ADDR_WIDTH-1:0]  id_read_address1_in;
    logic [REG_ADDR_WIDTH-1:0]  id_read_address2_in;
    logic                       id_uses_rs2_in;
    logic                       ex_mem_data_rd_en_in;
    logic [REG_ADDR_WIDTH-1:0]  ex_reg_wr_addr_in;
    logic                       ex_branch_taken_in;
    logic                       mem_req_in;
    logic                       mem_ready_in;

    logic                       pc_wr_en_out;
    logic                       if_id_wr_en_out;
    logic                       id_ex_wr_en_out;
    logic                       ex_mem_wr_en_out;
    logic                       mem_wb_wr_en_out;
    logic                       if_id_flush_out;
    logic                       id_ex_flush_out;
    logic [1:0]                 state_out;
    logic [STALL_CNT_WIDTH-1:0] stall_cycles_out;
    logic                       mem_timeout_err_out;

    modport master (
        output id_valid_in, id_read_address1_in, id_read_address2_in, id_uses_rs2_in,
        output ex_mem_data_rd_en_in, ex_reg_wr_addr_in, ex_branch_taken_in,
        output mem_req_in, mem_ready_in,
        input  pc_wr_en_out, if_id_wr_en_out, id_ex_wr_en_out, ex_mem_wr_en_out,
        input  mem_wb_wr_en_out, if_id_flush_out, id_ex_flush_out,
        input  state_out, stall_cycles_out, mem_timeout_err_out
    );

    modport slave (
        input  id_valid_in, id_read_address1_in, id_read_address2_in, id_uses_rs2_in,
        input  ex_mem_data_rd_en_in, ex_reg_wr_addr_in, ex_branch_taken_in,
        input  mem_req_in, mem_ready_in,
        output pc_wr_en_out, if_id_wr_en_out, id_ex_wr_en_out, ex_mem_wr_en_out,
        output mem_wb_wr_en_out, if_id_flush_out, id_ex_flush_out,
        output state_out, stall_cycles_out, mem_timeout_err_out
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller: load-use stalls, taken-branch squashes and
// data-memory freezes, with a sticky wait-timeout flag and a stall-cycle counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MEM_TIMEOUT     = 16,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave hcu
);

    localparam int WAIT_CNT_WIDTH = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LIMIT = WAIT_CNT_WIDTH'(MEM_TIMEOUT - 1);

    hcu_state_e                state_d;
    hcu_state_e                state_q;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q;
    logic                      timeout_err_d;
    logic                      timeout_err_q;

    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic                      load_use;
    logic                      frozen;
    stage_ctrl_t               ctrl;

    assign rs1   = hcu.id_read_address1_in;
    assign rs2   = hcu.id_read_address2_in;
    assign ex_rd = hcu.ex_reg_wr_addr_in;

    // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_use = hcu.ex_mem_data_rd_en_in
                   && (ex_rd != {REG_ADDR_WIDTH{1'b0}})
                   && hcu.id_valid_in
                   && ((rs1 == ex_rd) || (hcu.id_uses_rs2_in && (rs2 == ex_rd)));

    // Once waiting, only the ready strobe releases the freeze.
    assign frozen = (state_q == ST_MEM_WAIT) ? !hcu.mem_ready_in
                                             : (hcu.mem_req_in && !hcu.mem_ready_in);

    always_comb begin
        ctrl          = CTRL_NORMAL;
        state_d       = ST_RUN;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;

        if (reset) begin
            ctrl          = CTRL_RESET;
            wait_cnt_d    = '0;
            timeout_err_d = 1'b0;
        end else if (frozen) begin
            ctrl    = CTRL_FREEZE;
            state_d = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q == WAIT_LIMIT) begin
                timeout_err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
            end
        end else if (hcu.ex_branch_taken_in) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (load_use && (state_q != ST_LOAD_STALL)) begin
            ctrl.pc_wr_en    = 1'b0;
            ctrl.if_id_wr_en = 1'b0;
            ctrl.id_ex_flush = 1'b1;
            state_d          = ST_LOAD_STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    sat_counter #(
        .WIDTH (STALL_CNT_WIDTH)
    ) u_stall_counter (
        .clk       (clk),
        .clear     (reset),
        .en        (!ctrl.pc_wr_en),
        .count_out (hcu.stall_cycles_out)
    );

    assign hcu.pc_wr_en_out        = ctrl.pc_wr_en;
    assign hcu.if_id_wr_en_out     = ctrl.if_id_wr_en;
    assign hcu.id_ex_wr_en_out     = ctrl.id_ex_wr_en;
    assign hcu.ex_mem_wr_en_out    = ctrl.ex_mem_wr_en;
    assign hcu.mem_wb_wr_en_out    = ctrl.mem_wb_wr_en;
    assign hcu.if_id_flush_out     = ctrl.if_id_flush;
    assign hcu.id_ex_flush_out     = ctrl.id_ex_flush;
    assign hcu.state_out           = state_q;
    assign hcu.mem_timeout_err_out = timeout_err_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit; control vector order is
// {pc, if_id, id_ex, ex_mem, mem_wb wr_en, if_id_flush, id_ex_flush}.
module tb_hazard_control_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hazard_control_unit_if #(.REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)) hcu_if ();

    hazard_control_unit #(
        .REG_ADDR_WIDTH  (5),
        .MEM_TIMEOUT     (4),
        .STALL_CNT_WIDTH (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hcu   (hcu_if.slave)
    );

    logic [6:0] ctrl_obs;
    assign ctrl_obs = {hcu_if.pc_wr_en_out, hcu_if.if_id_wr_en_out, hcu_if.id_ex_wr_en_out,
                       hcu_if.ex_mem_wr_en_out, hcu_if.mem_wb_wr_en_out,
                       hcu_if.if_id_flush_out, hcu_if.id_ex_flush_out};

    localparam logic [6:0] C_NORMAL = 7'b1111100;
    localparam logic [6:0] C_FREEZE = 7'b0000000;
    localparam logic [6:0] C_RESET  = 7'b0000011;
    localparam logic [6:0] C_LDUSE  = 7'b0011101;
    localparam logic [6:0] C_SQUASH = 7'b1111111;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hcu_if.id_valid_in          = 1'b0;
        hcu_if.id_read_address1_in  = '0;
        hcu_if.id_read_address2_in  = '0;
        hcu_if.id_uses_rs2_in       = 1'b0;
        hcu_if.ex_mem_data_rd_en_in = 1'b0;
        hcu_if.ex_reg_wr_addr_in    = '0;
        hcu_if.ex_branch_taken_in   = 1'b0;
        hcu_if.mem_req_in           = 1'b0;
        hcu_if.mem_ready_in         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_load_use(input logic [4:0] ex_rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic uses_rs2);
        hcu_if.id_valid_in          = 1'b1;
        hcu_if.ex_mem_data_rd_en_in = 1'b1;
        hcu_if.ex_reg_wr_addr_in    = ex_rd;
        hcu_if.id_read_address1_in  = rs1;
        hcu_if.id_read_address2_in  = rs2;
        hcu_if.id_uses_rs2_in       = uses_rs2;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== C_RESET) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrl_obs, C_RESET);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd0 || hcu_if.mem_timeout_err_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: got state=%0d stall=%0d err=%b expected 0/0/0",
                     hcu_if.state_out, hcu_if.stall_cycles_out, hcu_if.mem_timeout_err_out);
        end
        checks++;
        if (ctrl_obs !== C_NORMAL) begin
            errors++;
            $display("[TB] FAIL idle_ctrl: got %b expected %b", ctrl_obs, C_NORMAL);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use(5'd3, 5'd3, 5'd7, 1'b1);
        #1;
        checks++;
        if (ctrl_obs !== C_LDUSE) begin
            errors++;
            $display("[TB] FAIL loaduse_ctrl: got %b expected %b", ctrl_obs, C_LDUSE);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd1) begin
            errors++;
            $display("[TB] FAIL loaduse_state: got %0d expected 1", hcu_if.state_out);
        end
        checks++;
        if (ctrl_obs !== C_NORMAL) begin
            errors++;
            $display("[TB] FAIL loaduse_suppress: got %b expected %b", ctrl_obs, C_NORMAL);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd1) begin
            errors++;
            $display("[TB] FAIL loaduse_after: got state=%0d stall=%0d expected 0/1",
                     hcu_if.state_out, hcu_if.stall_cycles_out);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        set_load_use(5'd0, 5'd0, 5'd0, 1'b1);
        #1;
        checks++;
        if (ctrl_obs !== C_NORMAL) begin
            errors++;
            $display("[TB] FAIL r0_no_stall: got %b expected %b", ctrl_obs, C_NORMAL);
        end
        step();
        set_load_use(5'd3, 5'd1, 5'd3, 1'b0);
        #1;
        checks++;
        if (ctrl_obs !== C_NORMAL) begin
            errors++;
            $display("[TB] FAIL rs2_unused: got %b expected %b", ctrl_obs, C_NORMAL);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL no_hazard_state: got state=%0d stall=%0d expected 0/0",
                     hcu_if.state_out, hcu_if.stall_cycles_out);
        end
        set_load_use(5'd3, 5'd1, 5'd3, 1'b1);
        #1;
        checks++;
        if (ctrl_obs !== C_LDUSE) begin
            errors++;
            $display("[TB] FAIL rs2_used: got %b expected %b", ctrl_obs, C_LDUSE);
        end
        hcu_if.id_valid_in = 1'b0;
        #1;
        checks++;
        if (ctrl_obs !== C_NORMAL) begin
            errors++;
            $display("[TB] FAIL id_invalid: got %b expected %b", ctrl_obs, C_NORMAL);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_load_use(5'd3, 5'd3, 5'd0, 1'b0);
        hcu_if.ex_branch_taken_in = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== C_SQUASH) begin
            errors++;
            $display("[TB] FAIL branch_ctrl: got %b expected %b", ctrl_obs, C_SQUASH);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL branch_state: got state=%0d stall=%0d expected 0/0",
                     hcu_if.state_out, hcu_if.stall_cycles_out);
        end
    endtask

    task automatic test_mem_freeze();
        do_reset();
        hcu_if.mem_req_in         = 1'b1;
        hcu_if.ex_branch_taken_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctrl_obs !== C_FREEZE) begin
                errors++;
                $display("[TB] FAIL freeze_ctrl[%0d]: got %b expected %b", i, ctrl_obs, C_FREEZE);
            end
            step();
            checks++;
            if (hcu_if.state_out !== 2'd2) begin
                errors++;
                $display("[TB] FAIL freeze_state[%0d]: got %0d expected 2", i, hcu_if.state_out);
            end
        end
        hcu_if.mem_ready_in = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== C_SQUASH) begin
            errors++;
            $display("[TB] FAIL release_branch: got %b expected %b", ctrl_obs, C_SQUASH);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd3 || hcu_if.mem_timeout_err_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_state: got state=%0d stall=%0d err=%b expected 0/3/0",
                     hcu_if.state_out, hcu_if.stall_cycles_out, hcu_if.mem_timeout_err_out);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hcu_if.mem_req_in = 1'b1;
        set_load_use(5'd9, 5'd9, 5'd0, 1'b0);
        step();
        hcu_if.mem_ready_in = 1'b1;
        #1;
        checks++;
        if (ctrl_obs !== C_LDUSE) begin
            errors++;
            $display("[TB] FAIL release_loaduse: got %b expected %b", ctrl_obs, C_LDUSE);
        end
        step();
        checks++;
        if (hcu_if.state_out !== 2'd1 || hcu_if.stall_cycles_out !== 16'd2) begin
            errors++;
            $display("[TB] FAIL release_loaduse_state: got state=%0d stall=%0d expected 1/2",
                     hcu_if.state_out, hcu_if.stall_cycles_out);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hcu_if.mem_req_in = 1'b1;
        repeat (4) step();
        checks++;
        if (hcu_if.mem_timeout_err_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: got %b expected 0", hcu_if.mem_timeout_err_out);
        end
        step();
        checks++;
        if (hcu_if.mem_timeout_err_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_set: got %b expected 1", hcu_if.mem_timeout_err_out);
        end
        repeat (3) step();
        checks++;
        if (hcu_if.mem_timeout_err_out !== 1'b1 || hcu_if.state_out !== 2'd2) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got err=%b state=%0d expected 1/2",
                     hcu_if.mem_timeout_err_out, hcu_if.state_out);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        hcu_if.mem_req_in = 1'b0;
        #1;
        checks++;
        if (hcu_if.mem_timeout_err_out !== 1'b0 || hcu_if.state_out !== 2'd0 || hcu_if.stall_cycles_out !== 16'd0) begin
            errors++;
            $display("[TB] FAIL timeout_reset: got err=%b state=%0d stall=%0d expected 0/0/0",
                     hcu_if.mem_timeout_err_out, hcu_if.state_out, hcu_if.stall_cycles_out);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        hcu_if.mem_req_in = 1'b1;
        repeat (65536 + 5) @(posedge clk);
        #1;
        checks++;
        if (hcu_if.stall_cycles_out !== 16'hFFFF) begin
            errors++;
            $display("[TB] FAIL stall_saturate: got %h expected ffff", hcu_if.stall_cycles_out);
        end
        hcu_if.mem_ready_in = 1'b1;
        step();
        checks++;
        if (hcu_if.stall_cycles_out !== 16'hFFFF || hcu_if.state_out !== 2'd0) begin
            errors++;
            $display("[TB] FAIL stall_hold: got stall=%h state=%0d expected ffff/0",
                     hcu_if.stall_cycles_out, hcu_if.state_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_mem_freeze();
        test_back_to_back();
        test_timeout();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
